// File: rtl/regfile_writeback_arbiter.sv
// Two-source writeback queueing and round-robin arbitration onto the single register file write port.
// Define REGFILE_WB_STATS_EN to add saturating wb_count / conflict_count outputs.
module regfile_writeback_arbiter #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 3,
  parameter int RAM_DEPTH     = 1 << ADDRESS_WIDTH,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [ADDRESS_WIDTH-1:0] alu_addr,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  output logic                     mem_ready,
  output logic                     write_en,
  output logic [ADDRESS_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0]    write_data,
  output logic [RAM_DEPTH-1:0]     pend_mask,
  output logic                     idle
`ifdef REGFILE_WB_STATS_EN
  ,
  output logic [15:0]              wb_count,
  output logic [15:0]              conflict_count
`endif
);

  localparam int   NSRC    = 2;
  localparam int   PTR_W   = $clog2(FIFO_DEPTH);
  localparam int   CNT_W   = PTR_W + 1;
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  logic [NSRC-1:0]          in_valid;
  logic [ADDRESS_WIDTH-1:0] in_addr   [NSRC];
  logic [DATA_WIDTH-1:0]    in_data   [NSRC];
  logic [NSRC-1:0]          ready_src;
  logic [NSRC-1:0]          nonempty_src;
  logic [NSRC-1:0]          push_src;
  logic [NSRC-1:0]          pop_src;
  logic [ADDRESS_WIDTH-1:0] head_addr [NSRC];
  logic [DATA_WIDTH-1:0]    head_data [NSRC];
  logic [RAM_DEPTH-1:0]     pend_src  [NSRC];
  logic                     last_grant_reg;
  logic                     grant_mem;

  assign in_valid   = {mem_valid, alu_valid};
  assign in_addr[0] = alu_addr;
  assign in_addr[1] = mem_addr;
  assign in_data[0] = alu_data;
  assign in_data[1] = mem_data;
  assign alu_ready  = ready_src[0];
  assign mem_ready  = ready_src[1];

  // MEM wins when it is the only requester or when ALU was granted last.
  assign grant_mem = nonempty_src[1] && (!nonempty_src[0] || last_grant_reg == SRC_ALU);
  assign pop_src   = {grant_mem, nonempty_src[0] && !grant_mem};

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_fifo
      logic [ADDRESS_WIDTH-1:0] addr_mem [FIFO_DEPTH];
      logic [DATA_WIDTH-1:0]    data_mem [FIFO_DEPTH];
      logic [PTR_W-1:0]         wr_ptr_reg;
      logic [PTR_W-1:0]         rd_ptr_reg;
      logic [CNT_W-1:0]         count_reg;
      logic [RAM_DEPTH-1:0]     pend_next;

      // Ready depends on count alone, so a full FIFO never accepts even while popping.
      assign ready_src[gi]    = count_reg < CNT_W'(FIFO_DEPTH);
      assign nonempty_src[gi] = count_reg != '0;
      assign push_src[gi]     = in_valid[gi] && ready_src[gi];
      assign head_addr[gi]    = addr_mem[rd_ptr_reg];
      assign head_data[gi]    = data_mem[rd_ptr_reg];
      assign pend_src[gi]     = pend_next;

      always_ff @(posedge clk) begin
        if (push_src[gi]) begin
          addr_mem[wr_ptr_reg] <= in_addr[gi];
          data_mem[wr_ptr_reg] <= in_data[gi];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push_src[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop_src[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
          case ({push_src[gi], pop_src[gi]})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
          endcase
        end
      end

      always_comb begin
        pend_next = '0;
        for (int e = 0; e < FIFO_DEPTH; e++) begin
          if (CNT_W'(e) < count_reg) pend_next[addr_mem[rd_ptr_reg + PTR_W'(e)]] = 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      write_en       <= 1'b0;
      write_addr     <= '0;
      write_data     <= '0;
      last_grant_reg <= SRC_ALU;
    end else if (grant_mem) begin
      write_en       <= 1'b1;
      write_addr     <= head_addr[1];
      write_data     <= head_data[1];
      last_grant_reg <= SRC_MEM;
    end else if (pop_src[0]) begin
      write_en       <= 1'b1;
      write_addr     <= head_addr[0];
      write_data     <= head_data[0];
      last_grant_reg <= SRC_ALU;
    end else begin
      write_en <= 1'b0;
    end
  end

  always_comb begin
    pend_mask = pend_src[0] | pend_src[1];
    if (write_en) pend_mask[write_addr] = 1'b1;
  end

  assign idle = !nonempty_src[0] && !nonempty_src[1] && !write_en;

`ifdef REGFILE_WB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_count       <= '0;
      conflict_count <= '0;
    end else begin
      if (write_en && wb_count != 16'hFFFF) wb_count <= wb_count + 16'd1;
      if (&nonempty_src && conflict_count != 16'hFFFF) conflict_count <= conflict_count + 16'd1;
    end
  end
`endif

endmodule
